srff_bank: RTL and testbench

//  Parametrised bank of WIDTH independent SR flip-flops sharing one clock, enable and reset.
//  The S=R=1 case has a selectable, fully defined resolution mode instead of being left undetermined.

---
 rtl/srff_bank.sv | 109 ++++++++++
 tb/tb_srff_bank.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/srff_bank.sv
`default_nettype none
// ============================================================================
// Module  : srff_bank
// Brief   : Bank of WIDTH SR flip-flops with a defined S=R=1 resolution,
//           sticky per-channel conflict flags and a saturating conflict counter.
// Revision: 1.0  initial release
// ============================================================================
module srff_bank #(
    parameter int               WIDTH   = 4,
    parameter int               MODE    = 0,
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter int               CNT_W   = 8,
    parameter int               NEGEDGE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] conflict,
    output logic             conflict_any,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_conflict;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_new_conf;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_conf_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_new_conf = en ? (s & r) : '0;

    always_comb begin
        w_q_nxt = r_q;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({s[i], r[i]})
                    2'b01:   w_q_nxt[i] = 1'b0;
                    2'b10:   w_q_nxt[i] = 1'b1;
                    2'b11: begin
                        case (MODE)
                            1:       w_q_nxt[i] = 1'b1;
                            2:       w_q_nxt[i] = 1'b0;
                            3:       w_q_nxt[i] = ~r_q[i];
                            default: w_q_nxt[i] = r_q[i];
                        endcase
                    end
                    default: w_q_nxt[i] = r_q[i];
                endcase
            end
        end
    end

    // A conflict arriving with clr_err survives the clear.
    always_comb begin
        w_conf_nxt = clr_err ? w_new_conf : (r_conflict | w_new_conf);
        w_cnt_nxt  = r_cnt;
        if (clr_err) begin
            w_cnt_nxt = (|w_new_conf) ? c_CNT_ONE : '0;
        end else if ((|w_new_conf) && (r_cnt != c_CNT_MAX)) begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
    end

    generate
        if (NEGEDGE != 0) begin : g_negedge
            always_ff @(negedge clk) begin
                if (!reset) begin
                    r_q        <= INIT;
                    r_conflict <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_q        <= w_q_nxt;
                    r_conflict <= w_conf_nxt;
                    r_cnt      <= w_cnt_nxt;
                end
            end
        end else begin : g_posedge
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_q        <= INIT;
                    r_conflict <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_q        <= w_q_nxt;
                    r_conflict <= w_conf_nxt;
                    r_cnt      <= w_cnt_nxt;
                end
            end
        end
    endgenerate

    assign q            = r_q;
    assign q_n          = ~r_q;
    assign conflict     = r_conflict;
    assign conflict_any = |r_conflict;
    assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_srff_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_srff_bank
// Brief   : Four falling-edge instances (MODE 0..3) and one rising-edge
//           instance (MODE 3) driven by one stimulus, checked against a model.
// Revision: 1.0  initial release
// ============================================================================
module tb_srff_bank;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       en_i = 1'b0;
    logic [3:0] s_i = 4'h0;
    logic [3:0] r_i = 4'h0;
    logic       clr_i = 1'b0;

    logic [3:0] q_o    [4];
    logic [3:0] qn_o   [4];
    logic [3:0] conf_o [4];
    logic       any_o  [4];
    logic [1:0] cnt_o  [4];

    logic [3:0] q_p, qn_p, conf_p;
    logic       any_p;
    logic [1:0] cnt_p;

    int m_q [5];
    int m_conf [5];
    int m_cnt [5];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_dut
            srff_bank #(.WIDTH(4), .MODE(k), .INIT(4'h0), .CNT_W(2), .NEGEDGE(1)) u_dut (
                .clk(clk), .reset(reset_i), .en(en_i), .s(s_i), .r(r_i), .clr_err(clr_i),
                .q(q_o[k]), .q_n(qn_o[k]), .conflict(conf_o[k]),
                .conflict_any(any_o[k]), .conflict_cnt(cnt_o[k])
            );
        end
    endgenerate

    srff_bank #(.WIDTH(4), .MODE(3), .INIT(4'h0), .CNT_W(2), .NEGEDGE(0)) u_dut_pos (
        .clk(clk), .reset(reset_i), .en(en_i), .s(s_i), .r(r_i), .clr_err(clr_i),
        .q(q_p), .q_n(qn_p), .conflict(conf_p),
        .conflict_any(any_p), .conflict_cnt(cnt_p)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: one active edge applied to model slot k with resolution mode md.
    task automatic model_update(input int k, input int md);
        int conf_bits, nq, bs, br, cur, nb;
        if (!reset_i) begin
            m_q[k] = 0; m_conf[k] = 0; m_cnt[k] = 0;
            return;
        end
        conf_bits = en_i ? int'(s_i & r_i) : 0;
        nq = m_q[k];
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                bs  = (int'(s_i) >> i) & 1;
                br  = (int'(r_i) >> i) & 1;
                cur = (m_q[k] >> i) & 1;
                nb  = cur;
                if (bs == 1 && br == 0) nb = 1;
                else if (bs == 0 && br == 1) nb = 0;
                else if (bs == 1 && br == 1) begin
                    if (md == 1) nb = 1;
                    else if (md == 2) nb = 0;
                    else if (md == 3) nb = 1 - cur;
                end
                nq = (nq & ~(1 << i)) | (nb << i);
            end
        end
        m_q[k] = nq;
        m_conf[k] = clr_i ? conf_bits : (m_conf[k] | conf_bits);
        if (clr_i) m_cnt[k] = (conf_bits != 0) ? 1 : 0;
        else if (conf_bits != 0 && m_cnt[k] < 3) m_cnt[k] = m_cnt[k] + 1;
    endtask

    // Called at rising edge + 1; returns at the following rising edge + 1.
    task automatic step(input logic rst, input logic en, input logic [3:0] s,
                        input logic [3:0] r, input logic clr);
        reset_i = rst; en_i = en; s_i = s; r_i = r; clr_i = clr;
        @(negedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            model_update(k, k);
            chk($sformatf("q_m%0d", k),    int'(q_o[k]),    m_q[k]);
            chk($sformatf("qn_m%0d", k),   int'(qn_o[k]),   (~m_q[k]) & 15);
            chk($sformatf("conf_m%0d", k), int'(conf_o[k]), m_conf[k]);
            chk($sformatf("any_m%0d", k),  int'(any_o[k]),  (m_conf[k] != 0) ? 1 : 0);
            chk($sformatf("cnt_m%0d", k),  int'(cnt_o[k]),  m_cnt[k]);
        end
        chk("pos_q_stable_on_fall", int'(q_p), m_q[4]);
        @(posedge clk); #1;
        model_update(4, 3);
        chk("pos_q",    int'(q_p),    m_q[4]);
        chk("pos_qn",   int'(qn_p),   (~m_q[4]) & 15);
        chk("pos_conf", int'(conf_p), m_conf[4]);
        chk("pos_any",  int'(any_p),  (m_conf[4] != 0) ? 1 : 0);
        chk("pos_cnt",  int'(cnt_p),  m_cnt[4]);
    endtask

    initial begin
        int exp_q2 [4];
        int exp_cnt3 [5];
        exp_q2 = '{1, 3, 0, 2};
        exp_cnt3 = '{1, 2, 3, 3, 3};
        for (int k = 0; k < 5; k++) begin
            m_q[k] = 0; m_conf[k] = 0; m_cnt[k] = 0;
        end
        @(posedge clk); #1;

        // Reset with a pending set request.
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        chk("rst_q",   int'(q_o[0]),    0);
        chk("rst_qn",  int'(qn_o[0]),   15);
        chk("rst_cnt", int'(cnt_o[0]),  0);
        chk("rst_conf", int'(conf_o[0]), 0);
        step(1'b1, 1'b1, 4'b0101, 4'b0010, 1'b0);
        chk("first_upd_q", int'(q_o[0]), 5);

        // Bring q to 0001, then S=R=1 on two channels.
        step(1'b1, 1'b1, 4'b0000, 4'b0100, 1'b0);
        step(1'b1, 1'b1, 4'b0011, 4'b0011, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mode%0d_q", k),    int'(q_o[k]),    exp_q2[k]);
            chk($sformatf("mode%0d_conf", k), int'(conf_o[k]), 3);
            chk($sformatf("mode%0d_cnt", k),  int'(cnt_o[k]),  1);
        end

        // Saturation then clear.
        step(1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0);
            chk($sformatf("sat_cnt%0d", n), int'(cnt_o[0]), exp_cnt3[n]);
        end
        step(1'b1, 1'b1, 4'b0001, 4'b0010, 1'b1);
        chk("clr_cnt",  int'(cnt_o[0]),  0);
        chk("clr_conf", int'(conf_o[0]), 0);

        // Clear coinciding with a new conflict: set wins.
        step(1'b1, 1'b1, 4'b0001, 4'b0001, 1'b0);
        step(1'b1, 1'b1, 4'b1000, 4'b1000, 1'b1);
        chk("clrset_conf", int'(conf_o[1]), 8);
        chk("clrset_cnt",  int'(cnt_o[1]),  1);

        // Disabled updates, then a one-edge reset pulse.
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 4'hF, 4'hF, 1'b0);
        chk("en0_conf", int'(conf_o[2]), 8);
        chk("en0_cnt",  int'(cnt_o[2]),  1);
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
        chk("pulse_rst_q", int'(q_o[1]), 0);

        // Randomized traffic.
        for (int n = 0; n < 120; n++) begin
            step(($urandom_range(0, 24) != 0), ($urandom_range(0, 4) != 0),
                 4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
